// File: rtl/ram_port_ctrl_pkg.sv
// ram_port_ctrl_pkg: shared types and constants for the RAM port-A front-end.
//   t_rpc_state : FSM state encoding used by ram_port_ctrl
//   BE_ALL_ONES : all-ones byte-enable pattern. It is wide enough for data
//                 words up to 512 bits; users slice it down to their BE width.
package ram_port_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_DATA  = 2'd1,
    RMW      = 2'd2,
    RSP_HOLD = 2'd3
  } t_rpc_state;

  localparam int                 BE_ALL_ONES_W = 64;
  localparam logic [BE_ALL_ONES_W-1:0] BE_ALL_ONES = {BE_ALL_ONES_W{1'b1}};

endpackage

// File: rtl/ram_byte_merge.sv
// ram_byte_merge: combinational byte-lane merge.
//   old_data : word currently held in memory
//   new_data : word carrying the bytes to be written
//   be       : byte enables, one per byte lane of the word
//   merged   : each byte i comes from new_data when be[i] is set, else from old_data
module ram_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Select each byte lane independently from the old or the new word.
  always_comb begin
    merged = old_data;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_data[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: valid/ready load/store front-end for port A of a
// synchronous-read RAM (one-cycle registered read, no byte enables).
//   clock, rstn             : clock shared with the RAM, async active-low reset
//   req_valid/req_ready     : request handshake; one operation in flight at a time
//   req_wr/addr/wdata/be    : store flag, word address, store data, byte enables
//   rsp_valid/rsp_ready     : response handshake; fields held stable until consumed
//   rsp_wr/rsp_rdata        : echo of the store flag, load data (0 for stores)
//   ram_address/data/wren   : RAM port-A address, write data and write enable
//   ram_q                   : RAM port-A read data, valid one cycle after the address
// Partial stores are done as read-modify-write: read in the accept cycle and
// write the merged word in the following cycle. A port-B write to the same word
// between those two cycles is overwritten; software has to avoid that case.
module ram_port_ctrl
  import ram_port_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_wr,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [DATA_WIDTH-1:0]   ram_data,
  output logic                    ram_wren,
  input  logic [DATA_WIDTH-1:0]   ram_q
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [BE_WIDTH-1:0] BE_FULL = BE_ALL_ONES[BE_WIDTH-1:0];
  localparam logic [BE_WIDTH-1:0] BE_NONE = {BE_WIDTH{1'b0}};

  t_rpc_state            state_r;
  t_rpc_state            state_s;
  logic                  run_r;      // low while in reset and for the first edge after it
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  accept_s;
  logic                  hold_rd_s;
  logic [DATA_WIDTH-1:0] merged_s;

  ram_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_data (ram_q),
    .new_data (wdata_q),
    .be       (be_q),
    .merged   (merged_s)
  );

  // FSM state register plus the out-of-reset flag that keeps the port closed during reset.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      run_r   <= 1'b1;
    end
  end

  // Request capture on accept; load data is parked in rdata_q when the response stalls.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      be_q    <= {BE_WIDTH{1'b0}};
      wr_q    <= 1'b0;
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
      wr_q    <= req_wr;
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (hold_rd_s) begin
      rdata_q <= ram_q;
    end
  end

  // Next-state and output decode; port A follows req_addr only while idle.
  always_comb begin
    state_s     = state_r;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_wr      = 1'b0;
    rsp_rdata   = {DATA_WIDTH{1'b0}};
    ram_address = addr_q;
    ram_data    = {DATA_WIDTH{1'b0}};
    ram_wren    = 1'b0;
    accept_s    = 1'b0;
    hold_rd_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_r) begin
          req_ready   = 1'b1;
          ram_address = req_addr;
          if (req_valid) begin
            accept_s = 1'b1;
            if (!req_wr) begin
              state_s = RD_DATA;
            end else if (req_be == BE_FULL) begin
              // Full-word store goes straight to the RAM in the accept cycle.
              ram_wren = 1'b1;
              ram_data = req_wdata;
              state_s  = RSP_HOLD;
            end else if (req_be == BE_NONE) begin
              state_s = RSP_HOLD;
            end else begin
              // Partial store: this cycle is the read half of the RMW.
              state_s = RMW;
            end
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_DATA: begin
        rsp_valid = 1'b1;
        rsp_wr    = wr_q;
        rsp_rdata = ram_q;
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          // ram_q may change under a port-B write, so freeze the response here.
          hold_rd_s = 1'b1;
          state_s   = RSP_HOLD;
        end
      end
      RMW: begin
        ram_wren = 1'b1;
        ram_data = merged_s;
        state_s  = RSP_HOLD;
      end
      RSP_HOLD: begin
        rsp_valid = 1'b1;
        rsp_wr    = wr_q;
        rsp_rdata = rdata_q;
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RSP_HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: randomized self-checking bench for ram_port_ctrl.
// A dual-port RAM model (port B writes win) sits on port A; a word-level
// memory model predicts response data, write data and response latency.
module tb_ram_port_ctrl;

  logic        clock;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic [9:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  logic        b_wren;
  logic [9:0]  b_addr;
  logic [31:0] b_data;

  logic [31:0] ram_mem [0:1023];
  logic [31:0] exp_mem [0:1023];

  int          n_cmp;
  int          n_err;
  int          wren_total;
  bit          rsp_active;
  logic        exp_rsp_wr;
  logic [31:0] exp_rsp_rdata;
  logic [9:0]  exp_wr_addr;
  logic [31:0] exp_wr_data;

  ram_port_ctrl dut (
    .clock       (clock),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_wr      (rsp_wr),
    .rsp_rdata   (rsp_rdata),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Dual-port RAM: synchronous read on A, port B write applied last so it wins.
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    if (b_wren)   ram_mem[b_addr]      <= b_data;
    ram_q <= ram_mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of the DUT against the model, sampled late in the low phase.
  always @(negedge clock) begin
    #4;
    if (!rstn) begin
      chk("reset_wren", ram_wren, 32'd0);
      chk("reset_rsp_valid", rsp_valid, 32'd0);
      chk("reset_req_ready", req_ready, 32'd0);
      chk("reset_address", ram_address, 32'd0);
    end else if (rsp_active) begin
      if (ram_wren) begin
        wren_total++;
        chk("wr_addr", ram_address, exp_wr_addr);
        chk("wr_data", ram_data, exp_wr_data);
      end
      if (rsp_valid) begin
        chk("rsp_wr", rsp_wr, exp_rsp_wr);
        chk("rsp_rdata", rsp_rdata, exp_rsp_rdata);
      end
    end else begin
      chk("wren_idle", ram_wren, 32'd0);
      chk("rsp_idle", rsp_valid, 32'd0);
    end
  end

  task automatic junk_req();
    req_valid = 1'($urandom_range(0, 1));
    req_wr    = 1'($urandom_range(0, 1));
    req_addr  = 10'($urandom);
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic b_write(input logic [9:0] addr, input logic [31:0] data);
    @(negedge clock);
    b_wren = 1'b1; b_addr = addr; b_data = data;
    exp_mem[addr] = data;
    @(negedge clock);
    b_wren = 1'b0;
  endtask

  // One request/response transaction; stall = cycles rsp_ready is held low.
  task automatic do_op(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall, input bit b_hit,
                       output logic [31:0] got);
    logic [31:0] mask;
    logic [31:0] old_w;
    logic [31:0] new_w;
    int          lat;
    int          waited;
    int          wren_start;
    int          exp_writes;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    old_w      = exp_mem[addr];
    new_w      = (wdata & mask) | (old_w & ~mask);
    lat        = (wr && be != 4'h0 && be != 4'hF) ? 2 : 1;
    exp_writes = (wr && be != 4'h0) ? 1 : 0;
    @(negedge clock);
    exp_rsp_wr    = wr;
    exp_rsp_rdata = wr ? 32'h0 : old_w;
    exp_wr_addr   = addr;
    exp_wr_data   = new_w;
    wren_start    = wren_total;
    rsp_active    = 1'b1;
    if (exp_writes == 1) exp_mem[addr] = new_w;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = (stall == 0);
    #3;
    chk("req_ready_idle", req_ready, 32'd1);
    waited = 0;
    do begin
      @(negedge clock);
      junk_req();
      #3;
      waited++;
    end while (!rsp_valid && waited < 6);
    chk("rsp_latency", waited, lat);
    got = rsp_rdata;
    for (int s = 0; s < stall; s++) begin
      chk("req_ready_busy", req_ready, 32'd0);
      chk("rsp_valid_held", rsp_valid, 32'd1);
      if (s == 0 && b_hit) begin
        b_wren = 1'b1; b_addr = addr; b_data = $urandom;
        exp_mem[addr] = b_data;
      end
      @(negedge clock);
      b_wren = 1'b0;
      junk_req();
      if (s == stall - 1) rsp_ready = 1'b1;
      #3;
    end
    @(negedge clock);
    req_valid  = 1'b0;
    rsp_active = 1'b0;
    #3;
    chk("req_ready_after", req_ready, 32'd1);
    chk("rsp_valid_after", rsp_valid, 32'd0);
    chk("wren_count", wren_total - wren_start, exp_writes);
  endtask

  initial begin
    logic [31:0] got;
    logic [9:0]  a;
    int          pick;
    n_cmp = 0; n_err = 0; wren_total = 0; rsp_active = 1'b0;
    exp_rsp_wr = 1'b0; exp_rsp_rdata = 32'h0; exp_wr_addr = 10'h0; exp_wr_data = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    b_wren = 1'b0; b_addr = 10'h0; b_data = 32'h0;
    rsp_ready = 1'b1;
    rstn = 1'b0;
    // A full store presented during reset must not reach the RAM.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h3FF; req_wdata = 32'hFFFF0000; req_be = 4'hF;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_req_ready", req_ready, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_ram_wren", ram_wren, 32'd0);
    chk("rst_ram_address", ram_address, 32'd0);
    req_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clock);
    #3;
    chk("post_rst_req_ready", req_ready, 32'd1);
    chk("post_rst_mem", ram_mem[10'h3FF], 32'h0);

    // Full store then load.
    do_op(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 0, 1'b0, got);
    chk("store_rdata_zero", got, 32'h0);
    do_op(1'b0, 10'h005, 32'h0, 4'h0, 0, 1'b0, got);
    chk("load_005", got, 32'hDEADBEEF);

    // Partial store as read-modify-write.
    b_write(10'h010, 32'h11223344);
    do_op(1'b1, 10'h010, 32'hAABBCCDD, 4'b0101, 0, 1'b0, got);
    chk("rmw_model_word", exp_mem[10'h010], 32'h11BB33DD);
    do_op(1'b0, 10'h010, 32'h0, 4'h0, 0, 1'b0, got);
    chk("load_010", got, 32'h11BB33DD);

    // Back-pressured load with a port-B write to the same word while held.
    do_op(1'b0, 10'h005, 32'h0, 4'h0, 4, 1'b1, got);
    chk("bp_load_005", got, 32'hDEADBEEF);
    do_op(1'b0, 10'h005, 32'h0, 4'h0, 0, 1'b0, got);

    // Store with no byte enables leaves memory alone.
    b_write(10'h020, 32'h12345678);
    do_op(1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, 0, 1'b0, got);
    do_op(1'b0, 10'h020, 32'h0, 4'h0, 0, 1'b0, got);
    chk("be0_load_020", got, 32'h12345678);

    // Reset while the RMW write is on the port.
    b_write(10'h040, 32'hCAFEF00D);
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h040; req_wdata = 32'h99999999; req_be = 4'b0011;
    rsp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    chk("rmw_wren_pre_reset", ram_wren, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rmw_reset_wren", ram_wren, 32'd0);
    chk("rmw_reset_rsp_valid", rsp_valid, 32'd0);
    @(negedge clock);
    @(negedge clock);
    #1;
    rstn = 1'b1;
    @(negedge clock);
    #3;
    chk("rmw_reset_req_ready", req_ready, 32'd1);
    repeat (3) @(negedge clock);
    do_op(1'b0, 10'h040, 32'h0, 4'h0, 0, 1'b0, got);
    chk("rmw_reset_load_040", got, 32'hCAFEF00D);

    // Edge addresses.
    do_op(1'b1, 10'h3FF, 32'h0BADF00D, 4'hF, 0, 1'b0, got);
    do_op(1'b1, 10'h000, 32'h600DCAFE, 4'hF, 0, 1'b0, got);
    do_op(1'b0, 10'h3FF, 32'h0, 4'h0, 0, 1'b0, got);
    chk("load_3ff", got, 32'h0BADF00D);
    do_op(1'b0, 10'h000, 32'h0, 4'h0, 0, 1'b0, got);
    chk("load_000", got, 32'h600DCAFE);

    // Randomized traffic over a small address pool plus the edge words.
    for (int k = 0; k < 400; k++) begin
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      a = 10'h3FF;
      else if (pick == 1) a = 10'h000;
      else                a = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) b_write(a, $urandom);
      do_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
            1'($urandom_range(0, 1)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
